// File: rtl/fifo_drain_uart_tx.sv
// rtl/fifo_drain_uart_tx.sv - pops FIFO words and sends them LSB-first as start/data/stop serial frames
// Define FIFO_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module fifo_drain_uart_tx #(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             fifo_rd_en,
  output logic             tx_out,
  output logic             busy,
  output logic [7:0]       frame_cnt
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_POP    = 3'd1;
  localparam logic [2:0] S_LATCH  = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_DATA   = 3'd4;
  localparam logic [2:0] S_STOP   = 3'd5;
`ifdef FIFO_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd6;
`endif

  logic [2:0]       r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_clk_cnt;
  logic [BW-1:0]    r_bit_cnt;
  logic             r_tx;
  logic [7:0]       r_frame_cnt;
`ifdef FIFO_TX_PARITY_EN
  logic             r_parity;
`endif

  logic w_bit_end;

  assign w_bit_end  = (r_clk_cnt == CLK_LAST);
  // Gated by rst_n so a queued word is never popped while the block is held in reset.
  assign fifo_rd_en = rst_n && (r_state == S_IDLE) && ena && !fifo_empty;
  assign tx_out     = r_tx;
  assign busy       = (r_state != S_IDLE);
  assign frame_cnt  = r_frame_cnt;

  // r_tx is loaded with the level of the state being entered, so the line follows the state exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_shreg     <= '0;
      r_clk_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_tx        <= 1'b1;
      r_frame_cnt <= 8'd0;
`ifdef FIFO_TX_PARITY_EN
      r_parity    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (fifo_rd_en) r_state <= S_POP;
        end
        S_POP: begin
          r_state <= S_LATCH;
        end
        S_LATCH: begin
          r_shreg   <= fifo_rdata;
`ifdef FIFO_TX_PARITY_EN
          r_parity  <= ^fifo_rdata;
`endif
          r_clk_cnt <= '0;
          r_bit_cnt <= '0;
          r_tx      <= 1'b0;
          r_state   <= S_START;
        end
        S_START: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            r_tx      <= r_shreg[0];
            r_state   <= S_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            r_shreg   <= r_shreg >> 1;
            if (r_bit_cnt == BIT_LAST) begin
`ifdef FIFO_TX_PARITY_EN
              r_tx    <= r_parity;
              r_state <= S_PARITY;
`else
              r_tx    <= 1'b1;
              r_state <= S_STOP;
`endif
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_tx      <= r_shreg[1];
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
`ifdef FIFO_TX_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            r_tx      <= 1'b1;
            r_state   <= S_STOP;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (w_bit_end) begin
            r_clk_cnt   <= '0;
            r_frame_cnt <= r_frame_cnt + 8'd1;
            r_state     <= S_IDLE;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
